// File: rtl/ccff_pkg.sv
// Shared types for the configuration-chain loader.
// State encoding and LOAD/READ mode constants.
package ccff_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_READ,
    ST_FIN
  } ccff_state_e;

  localparam logic CCFF_LOAD = 1'b0;
  localparam logic CCFF_READ = 1'b1;

endpackage

// File: rtl/ccff_clkgen.sv
// Bit-period generator: phase counter, registered prog_clk and strobes.
// Ports: advance in; prog_clk, head_upd, tail_smp, bit_end out.
module ccff_clkgen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic advance,
  output logic prog_clk,
  output logic head_upd,
  output logic tail_smp,
  output logic bit_end
);

  localparam int PW = $clog2(2 * CLK_DIV);
  localparam logic [PW-1:0] LO_END = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] HI_BEG = PW'(CLK_DIV);
  localparam logic [PW-1:0] HI_END = PW'(2 * CLK_DIV - 1);

  logic [PW-1:0] ph;
  logic [PW-1:0] ph_nxt;
  logic          stall;

  // A period may only start at phase 0; once started it runs to the end.
  assign stall    = (ph == '0) && !advance;
  assign head_upd = (ph == '0) && advance;
  assign tail_smp = (ph == LO_END) && !stall;

  always_comb begin
    ph_nxt = ph;
    if (!stall) begin
      ph_nxt = (ph == HI_END) ? '0 : ph + PW'(1);
    end
  end

  // prog_clk and bit_end lag the phase by one cycle, so a head
  // update becomes visible together with the falling prog_clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph       <= '0;
      prog_clk <= 1'b0;
      bit_end  <= 1'b0;
    end else begin
      ph       <= ph_nxt;
      prog_clk <= (ph >= HI_BEG);
      bit_end  <= (ph == HI_END);
    end
  end

endmodule

// File: rtl/ccff_loader.sv
// Configuration-chain loader/reader driving prog_clk and ccff_head.
// Ports: start/mode cmd, in_* LOAD stream, out_* READ stream, chain pins.
module ccff_loader
  import ccff_pkg::*;
#(
  parameter int CHAIN_LEN = 512,
  parameter int CLK_DIV   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mode,
  output logic       busy,
  output logic       done,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       prog_clk,
  output logic       ccff_head,
  input  logic       ccff_tail
);

  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int RW = (CW > 4) ? CW : 4;
  localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN);

  ccff_state_e state;
  ccff_state_e state_nxt;

  logic [CW-1:0] cnt;
  logic          more;
  logic          start_acc;
  logic          accept;
  logic          advance;
  logic          head_upd;
  logic          tail_smp;
  logic          bit_end;

  logic [7:0]    sr;
  logic [3:0]    sr_cnt;
  logic [RW-1:0] rem;
  logic [3:0]    nb;

  logic [7:0]    cap;
  logic [3:0]    cap_cnt;
  logic [7:0]    cap_nxt;
  logic [3:0]    cap_cnt_nxt;
  logic          cap_flush;

  logic          head_q;
  logic          ov_q;
  logic [7:0]    od_q;

  ccff_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clk      (clk),
    .rst_n    (rst_n),
    .advance  (advance),
    .prog_clk (prog_clk),
    .head_upd (head_upd),
    .tail_smp (tail_smp),
    .bit_end  (bit_end)
  );

  // cnt counts bit periods already started.
  assign more      = (cnt != LAST);
  assign start_acc = start && (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_FIN);
  assign in_ready  = (state == ST_LOAD) && (sr_cnt == '0) && more;
  assign accept    = in_ready && in_valid;

  // Bits still needed; the final byte may carry fewer than 8.
  assign rem = RW'(CHAIN_LEN) - RW'(cnt);
  assign nb  = (rem > RW'(8)) ? 4'd8 : rem[3:0];

  assign cap_nxt     = {cap[6:0], ccff_tail};
  assign cap_cnt_nxt = cap_cnt + 4'd1;
  assign cap_flush   = (cap_cnt_nxt == 4'd8) || !more;

  assign ccff_head = head_q;
  assign out_valid = ov_q;
  assign out_data  = od_q;

  always_comb begin
    advance = 1'b0;
    unique case (1'b1)
      state == ST_LOAD: advance = more && (sr_cnt != '0 || in_valid);
      state == ST_READ: advance = more && !(ov_q && !out_ready);
      default:          advance = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = (mode == CCFF_READ) ? ST_READ : ST_LOAD;
        end
      end
      ST_LOAD, ST_READ: begin
        if (bit_end && !more) state_nxt = ST_FIN;
      end
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      sr      <= '0;
      sr_cnt  <= '0;
      cap     <= '0;
      cap_cnt <= '0;
      head_q  <= 1'b0;
    end else if (start_acc) begin
      cnt     <= '0;
      sr_cnt  <= '0;
      cap     <= '0;
      cap_cnt <= '0;
    end else begin
      if (head_upd) cnt <= cnt + CW'(1);
      // A byte may be taken early (during the previous high phase);
      // it then waits in sr until the next period starts.
      if (accept) begin
        if (head_upd) begin
          head_q <= in_data[7];
          sr     <= {in_data[6:0], 1'b0};
          sr_cnt <= nb - 4'd1;
        end else begin
          sr     <= in_data;
          sr_cnt <= nb;
        end
      end else if (head_upd && state == ST_LOAD) begin
        head_q <= sr[7];
        sr     <= {sr[6:0], 1'b0};
        sr_cnt <= sr_cnt - 4'd1;
      end
      // The tail is stable from the previous rise until the next one,
      // so the value seen at period start is the bit this period captures.
      if (head_upd && state == ST_READ) head_q <= ccff_tail;
      if (tail_smp && state == ST_READ) begin
        cap     <= cap_nxt;
        cap_cnt <= cap_flush ? 4'd0 : cap_cnt_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_q <= 1'b0;
      od_q <= '0;
    end else begin
      if (ov_q && out_ready) ov_q <= 1'b0;
      if (tail_smp && state == ST_READ && cap_flush) begin
        ov_q <= 1'b1;
        od_q <= cap_nxt << (4'd8 - cap_cnt_nxt);
      end
    end
  end

endmodule
